ptmch_trg_cnt_gen2: RTL and testbench

Parametrised multi-channel trigger-pulse event counter. It is the successor to the fixed 5-channel, rise-only pulse counter.
- Each channel: asynchronous TRG_PLS input -> synchroniser -> stability (glitch) filter -> programmable edge detector -> saturating counter.
- Adds per-channel clear, a global count enable, sticky saturation flags and a selectable page-address tap.
- Sits between the external flash-command trigger pins and the register interface / page-address generator.

---
 rtl/ptmch_trg_cnt_gen2_if.sv | 51 +++++
 rtl/ptmch_trg_cnt_gen2.sv | 202 ++++++++++++++++++++
 tb/tb_ptmch_trg_cnt_gen2.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ptmch_trg_cnt_gen2_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ptmch_trg_cnt_gen2_if
// Description : Signal bundle between the trigger-pin / register side and the
//               multi-channel trigger-pulse counter ptmch_trg_cnt_gen2.
//               master : drives triggers, edge mode, enable, clears, tap select
//               slave  : the counter; returns counters, flags and tap outputs
//               Optional snapshot signals exist only when
//               PTMCH_TRG_CNT_SNAPSHOT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ptmch_trg_cnt_gen2_if #(
    parameter int NUM_CH  = 5,
    parameter int CNT_W   = 32,
    parameter int PADDR_W = 8,
    parameter int SEL_W   = 4
);
    logic [NUM_CH-1:0]       TRG_PLS;       // asynchronous trigger pins
    logic [1:0]              EDGE_MODE;     // 00 rise, 01 fall, 10 both, 11 none
    logic                    CNT_EN;        // global count enable
    logic [NUM_CH-1:0]       CNT_CLR;       // per-channel clear strobe
    logic [NUM_CH*CNT_W-1:0] CNT_OUT;       // packed counters
    logic [NUM_CH-1:0]       SAT_FLAG;      // sticky saturation flags
    logic [SEL_W-1:0]        PAGEADDR_SEL;  // tap channel select
    logic [PADDR_W-1:0]      PADDR_CNT;     // registered low bits of tapped counter
    logic                    PLS_EDGE;      // registered edge strobe of tapped channel
`ifdef PTMCH_TRG_CNT_SNAPSHOT_EN
    logic                    SNAP_REQ;      // capture all counters into shadow copy
    logic                    SNAP_VALID;    // strobe one cycle after capture

    modport master (
        output TRG_PLS, EDGE_MODE, CNT_EN, CNT_CLR, PAGEADDR_SEL, SNAP_REQ,
        input  CNT_OUT, SAT_FLAG, PADDR_CNT, PLS_EDGE, SNAP_VALID
    );
    modport slave (
        input  TRG_PLS, EDGE_MODE, CNT_EN, CNT_CLR, PAGEADDR_SEL, SNAP_REQ,
        output CNT_OUT, SAT_FLAG, PADDR_CNT, PLS_EDGE, SNAP_VALID
    );
`else
    modport master (
        output TRG_PLS, EDGE_MODE, CNT_EN, CNT_CLR, PAGEADDR_SEL,
        input  CNT_OUT, SAT_FLAG, PADDR_CNT, PLS_EDGE
    );
    modport slave (
        input  TRG_PLS, EDGE_MODE, CNT_EN, CNT_CLR, PAGEADDR_SEL,
        output CNT_OUT, SAT_FLAG, PADDR_CNT, PLS_EDGE
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ptmch_trg_cnt_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ptmch_trg_cnt_gen2
// Description : Parametrised multi-channel trigger-pulse event counter.
//               Per channel: synchroniser -> glitch filter -> programmable
//               edge detector -> saturating counter with clear and sticky
//               saturation flag. A selectable tap feeds the page-address
//               generator (PADDR_CNT / PLS_EDGE).
// Ports       : CLK100M  - system clock
//               RESET_N  - asynchronous active-low reset
//               bus      - ptmch_trg_cnt_gen2_if.slave (triggers, mode,
//                          enable, clears, counters, flags, tap)
// Option      : PTMCH_TRG_CNT_SNAPSHOT_EN adds SNAP_REQ/SNAP_VALID and
//               presents a coherent shadow copy on CNT_OUT/SAT_FLAG.
// Revision    : 1.0 - initial release
// ============================================================================
module ptmch_trg_cnt_gen2 #(
    parameter int NUM_CH      = 5,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2,
    parameter int PADDR_W     = 8,
    parameter int SEL_W       = 4
) (
    input  wire logic           CLK100M,
    input  wire logic           RESET_N,
    ptmch_trg_cnt_gen2_if.slave bus
);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    // Select compare is widened so every channel index up to 15 stays
    // representable even when SEL_W is narrow.
    localparam int               c_sel_ext_w = (SEL_W > 5) ? SEL_W : 5;

    logic [NUM_CH*CNT_W-1:0] w_cnt_live_pk;
    logic [NUM_CH-1:0]       w_sat_live;
    logic [NUM_CH-1:0]       w_edge;
`ifdef PTMCH_TRG_CNT_SNAPSHOT_EN
    logic [NUM_CH*CNT_W-1:0] w_cnt_nxt_pk;
    logic [NUM_CH-1:0]       w_sat_nxt;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_filt;
        logic                   r_prev;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_sat;
        logic                   w_s;
        logic                   w_stable;
        logic                   w_rise;
        logic                   w_fall;
        logic                   w_edge_ch;
        logic [CNT_W-1:0]       w_cnt_d;
        logic                   w_sat_d;

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge CLK100M or negedge RESET_N) begin
            if (!RESET_N) begin
                r_sync <= '0;
                r_filt <= 1'b0;
                r_prev <= 1'b0;
                r_cnt  <= '0;
                r_sat  <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], bus.TRG_PLS[gi]};
                if (w_stable) begin
                    r_filt <= w_s;
                end
                // prev keeps tracking while counting is disabled, so
                // re-enabling never sees a stale level difference.
                r_prev <= r_filt;
                r_cnt  <= w_cnt_d;
                r_sat  <= w_sat_d;
            end
        end

        // Filtered level only moves once s has matched the last FILT_LEN-1
        // samples, i.e. FILT_LEN consecutive equal samples.
        if (FILT_LEN == 1) begin : g_nofilt
            assign w_stable = 1'b1;
        end else begin : g_filt
            logic [FILT_LEN-2:0] r_hist;

            always_ff @(posedge CLK100M or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_hist <= '0;
                end else begin
                    r_hist[0] <= w_s;
                    for (int k = 1; k < FILT_LEN-1; k++) begin
                        r_hist[k] <= r_hist[k-1];
                    end
                end
            end

            assign w_stable = (r_hist == {(FILT_LEN-1){w_s}});
        end

        assign w_rise    = r_filt & ~r_prev;
        assign w_fall    = ~r_filt & r_prev;
        assign w_edge_ch = (bus.EDGE_MODE == 2'b00) ? w_rise :
                           (bus.EDGE_MODE == 2'b01) ? w_fall :
                           (bus.EDGE_MODE == 2'b10) ? (w_rise | w_fall) :
                                                      1'b0;

        // Clear beats saturation hold, which beats a counted edge.
        always_comb begin
            w_cnt_d = r_cnt;
            w_sat_d = r_sat;
            if (bus.CNT_CLR[gi]) begin
                w_cnt_d = '0;
                w_sat_d = 1'b0;
            end else if (r_cnt == c_cnt_max) begin
                w_sat_d = 1'b1;
            end else if (bus.CNT_EN && w_edge_ch) begin
                w_cnt_d = r_cnt + 1'b1;
                if (w_cnt_d == c_cnt_max) begin
                    w_sat_d = 1'b1;
                end
            end
        end

        assign w_edge[gi]                        = w_edge_ch;
        assign w_sat_live[gi]                    = r_sat;
        assign w_cnt_live_pk[gi*CNT_W +: CNT_W] = r_cnt;
`ifdef PTMCH_TRG_CNT_SNAPSHOT_EN
        assign w_cnt_nxt_pk[gi*CNT_W +: CNT_W]  = w_cnt_d;
        assign w_sat_nxt[gi]                     = w_sat_d;
`endif
    end

    // ------------------------------------------------------------------
    // Page-address tap. Out-of-range selects fall back to channel 0. The
    // tapped count is the pre-increment value of the current cycle.
    // ------------------------------------------------------------------
    logic [c_sel_ext_w-1:0] w_sel_ext;
    logic [PADDR_W-1:0]     w_tap_cnt;
    logic                   w_tap_edge;
    logic [PADDR_W-1:0]     r_paddr;
    logic                   r_pls;

    assign w_sel_ext = c_sel_ext_w'(bus.PAGEADDR_SEL);

    always_comb begin
        w_tap_cnt  = w_cnt_live_pk[PADDR_W-1:0];
        w_tap_edge = w_edge[0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (w_sel_ext == c_sel_ext_w'(k)) begin
                w_tap_cnt  = w_cnt_live_pk[k*CNT_W +: PADDR_W];
                w_tap_edge = w_edge[k];
            end
        end
    end

    always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_paddr <= '0;
            r_pls   <= 1'b0;
        end else begin
            r_paddr <= w_tap_cnt;
            r_pls   <= w_tap_edge & bus.CNT_EN;
        end
    end

    assign bus.PADDR_CNT = r_paddr;
    assign bus.PLS_EDGE  = r_pls;

`ifdef PTMCH_TRG_CNT_SNAPSHOT_EN
    // Shadow copy takes the post-update values so an increment landing in
    // the capture cycle is included; clears touch only the live counters.
    logic [NUM_CH*CNT_W-1:0] r_snap_cnt;
    logic [NUM_CH-1:0]       r_snap_sat;
    logic                    r_snap_cap;
    logic                    r_snap_valid;

    always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_snap_cnt   <= '0;
            r_snap_sat   <= '0;
            r_snap_cap   <= 1'b0;
            r_snap_valid <= 1'b0;
        end else begin
            if (bus.SNAP_REQ) begin
                r_snap_cnt <= w_cnt_nxt_pk;
                r_snap_sat <= w_sat_nxt;
            end
            r_snap_cap   <= bus.SNAP_REQ;
            r_snap_valid <= r_snap_cap;
        end
    end

    assign bus.CNT_OUT    = r_snap_cnt;
    assign bus.SAT_FLAG   = r_snap_sat;
    assign bus.SNAP_VALID = r_snap_valid;
`else
    assign bus.CNT_OUT    = w_cnt_live_pk;
    assign bus.SAT_FLAG   = w_sat_live;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ptmch_trg_cnt_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ptmch_trg_cnt_gen2
// Description : Self-checking bench for ptmch_trg_cnt_gen2. Two instances
//               share one stimulus: A uses the default parameters, B uses
//               CNT_W=8, SYNC_STAGES=3, FILT_LEN=3, PADDR_W=4 so that
//               saturation and glitch rejection are reachable. A reference
//               model derived from the sampled-input history predicts every
//               output each cycle; directed checks cover the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptmch_trg_cnt_gen2;
    localparam int NCH = 5;
    localparam int S_A = 2, F_A = 2, W_A = 32, P_A = 8;
    localparam int S_B = 3, F_B = 3, W_B = 8,  P_B = 4;

    logic CLK100M = 1'b0;
    logic RESET_N;
    always #5 CLK100M = ~CLK100M;

    logic [NCH-1:0] trg;
    logic [1:0]     mode;
    logic           en;
    logic [NCH-1:0] clr;
    logic [3:0]     sel;

    ptmch_trg_cnt_gen2_if #(.NUM_CH(NCH), .CNT_W(W_A), .PADDR_W(P_A), .SEL_W(4)) bus_a ();
    ptmch_trg_cnt_gen2_if #(.NUM_CH(NCH), .CNT_W(W_B), .PADDR_W(P_B), .SEL_W(4)) bus_b ();

    assign bus_a.TRG_PLS = trg;  assign bus_b.TRG_PLS = trg;
    assign bus_a.EDGE_MODE = mode; assign bus_b.EDGE_MODE = mode;
    assign bus_a.CNT_EN = en;    assign bus_b.CNT_EN = en;
    assign bus_a.CNT_CLR = clr;  assign bus_b.CNT_CLR = clr;
    assign bus_a.PAGEADDR_SEL = sel; assign bus_b.PAGEADDR_SEL = sel;
`ifdef PTMCH_TRG_CNT_SNAPSHOT_EN
    assign bus_a.SNAP_REQ = 1'b0;
    assign bus_b.SNAP_REQ = 1'b0;
`endif

    ptmch_trg_cnt_gen2 #(.NUM_CH(NCH), .CNT_W(W_A), .SYNC_STAGES(S_A), .FILT_LEN(F_A),
                         .PADDR_W(P_A), .SEL_W(4)) dut_a (
        .CLK100M (CLK100M),
        .RESET_N (RESET_N),
        .bus     (bus_a)
    );

    ptmch_trg_cnt_gen2 #(.NUM_CH(NCH), .CNT_W(W_B), .SYNC_STAGES(S_B), .FILT_LEN(F_B),
                         .PADDR_W(P_B), .SEL_W(4)) dut_b (
        .CLK100M (CLK100M),
        .RESET_N (RESET_N),
        .bus     (bus_b)
    );

    // ---------------- reference model state ----------------
    logic [NCH-1:0] xs[$];          // input vector seen at each edge since reset
    logic [NCH-1:0] m_filt [2];
    logic [NCH-1:0] m_prev [2];
    logic [NCH-1:0] m_sat  [2];
    logic [31:0]    m_cnt  [2][NCH];
    logic [31:0]    m_paddr[2];
    logic           m_pls  [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        xs.delete();
        for (int i = 0; i < 2; i++) begin
            m_filt[i] = '0; m_prev[i] = '0; m_sat[i] = '0;
            m_paddr[i] = '0; m_pls[i] = 1'b0;
            for (int c = 0; c < NCH; c++) m_cnt[i][c] = '0;
        end
    endtask

    function automatic logic [NCH-1:0] get_x(input int idx);
        if (idx < 0) return '0;
        return xs[idx];
    endfunction

    // One clock edge of the behavioural model, using the inputs now applied.
    task automatic model_step();
        logic [NCH-1:0] e, nf, xa;
        logic [31:0]    maxv, pmask;
        int             n, s, f, w, p, tsel;
        logic           v0, same;
        xs.push_back(trg);
        n    = xs.size() - 1;
        tsel = (int'(sel) < NCH) ? int'(sel) : 0;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? S_A : S_B;
            f = (i == 0) ? F_A : F_B;
            w = (i == 0) ? W_A : W_B;
            p = (i == 0) ? P_A : P_B;
            maxv  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
            pmask = (32'd1 << p) - 32'd1;
            case (mode)
                2'b00:   e = m_filt[i] & ~m_prev[i];
                2'b01:   e = ~m_filt[i] & m_prev[i];
                2'b10:   e = m_filt[i] ^ m_prev[i];
                default: e = '0;
            endcase
            m_paddr[i] = m_cnt[i][tsel] & pmask;
            m_pls[i]   = e[tsel] & en;
            for (int c = 0; c < NCH; c++) begin
                if (clr[c]) begin
                    m_cnt[i][c] = '0; m_sat[i][c] = 1'b0;
                end else if (m_cnt[i][c] == maxv) begin
                    m_sat[i][c] = 1'b1;
                end else if (en && e[c]) begin
                    m_cnt[i][c] = m_cnt[i][c] + 1;
                    if (m_cnt[i][c] == maxv) m_sat[i][c] = 1'b1;
                end
            end
            // Filtered level = synchronised sample, once the last f
            // synchronised samples all agree.
            for (int c = 0; c < NCH; c++) begin
                xa = get_x(n - s);
                v0 = xa[c];
                same = 1'b1;
                for (int k = 1; k < f; k++) begin
                    xa = get_x(n - s - k);
                    if (xa[c] != v0) same = 1'b0;
                end
                nf[c] = same ? v0 : m_filt[i][c];
            end
            m_prev[i] = m_filt[i];
            m_filt[i] = nf;
        end
    endtask

    task automatic compare_all();
        logic [159:0] ea, eb;
        ea = '0; eb = '0;
        for (int c = 0; c < NCH; c++) begin
            ea[c*32 +: 32] = m_cnt[0][c];
            eb[c*8  +: 8]  = m_cnt[1][c][7:0];
        end
        check_val("cnt_a",   bus_a.CNT_OUT,   ea);
        check_val("sat_a",   bus_a.SAT_FLAG,  m_sat[0]);
        check_val("paddr_a", bus_a.PADDR_CNT, m_paddr[0]);
        check_val("pls_a",   bus_a.PLS_EDGE,  m_pls[0]);
        check_val("cnt_b",   bus_b.CNT_OUT,   eb);
        check_val("sat_b",   bus_b.SAT_FLAG,  m_sat[1]);
        check_val("paddr_b", bus_b.PADDR_CNT, m_paddr[1]);
        check_val("pls_b",   bus_b.PLS_EDGE,  m_pls[1]);
    endtask

    task automatic tick();
        model_step();
        @(negedge CLK100M);
        compare_all();
    endtask

    task automatic pulses(input int ch, input int num, input int hi, input int lo);
        for (int q = 0; q < num; q++) begin
            trg[ch] = 1'b1; repeat (hi) tick();
            trg[ch] = 1'b0; repeat (lo) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tmr[NCH];
        logic [31:0] saved_a, saved_b;

        trg = '0; mode = 2'b00; en = 1'b1; clr = '0; sel = 4'd2; RESET_N = 1'b0;
        reset_model();
        repeat (3) @(negedge CLK100M);
        check_val("rst_cnt_a", bus_a.CNT_OUT, '0);
        check_val("rst_cnt_b", bus_b.CNT_OUT, '0);
        compare_all();
        RESET_N = 1'b1;

        // Clean 10-cycle pulse on ch2: count on the 5th edge after first sample.
        trg[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) check_val("lat_before", bus_a.CNT_OUT[2*32 +: 32], 32'd0);
            if (k == 5) begin
                check_val("lat_at",    bus_a.CNT_OUT[2*32 +: 32], 32'd1);
                check_val("tap_pls",   bus_a.PLS_EDGE, 1'b1);
                check_val("tap_pre",   bus_a.PADDR_CNT, 8'd0);
            end
            if (k == 6) begin
                check_val("tap_pls_end", bus_a.PLS_EDGE, 1'b0);
                check_val("tap_post",    bus_a.PADDR_CNT, 8'd1);
            end
        end
        trg[2] = 1'b0;
        repeat (10) tick();
        for (int c = 0; c < NCH; c++)
            if (c != 2) check_val("idle_ch", bus_a.CNT_OUT[c*32 +: 32], 32'd0);

        // Short glitches on ch0 never pass the 3-deep filter of instance B.
        for (int q = 0; q < 4; q++) begin
            trg[0] = 1'b1; repeat (2) tick();
            trg[0] = 1'b0; repeat (3) tick();
        end
        pulses(0, 1, 6, 10);
        check_val("glitch_b", bus_b.CNT_OUT[0*8 +: 8], 8'd1);

        // Both edges on ch4, then mode "none".
        mode = 2'b10;
        pulses(4, 3, 6, 6);
        repeat (6) tick();
        check_val("both_a", bus_a.CNT_OUT[4*32 +: 32], 32'd6);
        check_val("both_b", bus_b.CNT_OUT[4*8 +: 8], 8'd6);
        mode = 2'b11;
        pulses(4, 3, 6, 6);
        repeat (6) tick();
        check_val("none_a", bus_a.CNT_OUT[4*32 +: 32], 32'd6);

        // Randomised traffic.
        for (int c = 0; c < NCH; c++) tmr[c] = $urandom_range(1, 7);
        for (int t = 0; t < 2000; t++) begin
            for (int c = 0; c < NCH; c++) begin
                tmr[c]--;
                if (tmr[c] == 0) begin
                    trg[c] = ~trg[c];
                    tmr[c] = $urandom_range(1, 7);
                end
                clr[c] = ($urandom_range(0, 63) == 0);
            end
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 9) != 0);
            sel = 4'($urandom_range(0, 15));
            tick();
        end
        clr = '0; en = 1'b1;

        // Saturation of ch1 on the 8-bit instance.
        mode = 2'b10; sel = 4'd1;
        repeat (12) tick();
        for (int q = 0; q < 300; q++) begin
            trg[1] = ~trg[1];
            repeat (4) tick();
        end
        repeat (12) tick();
        check_val("sat_cnt_b", bus_b.CNT_OUT[1*8 +: 8], 8'hFF);
        check_val("sat_flg_b", bus_b.SAT_FLAG[1], 1'b1);
        check_val("sat_flg_a", bus_a.SAT_FLAG[1], 1'b0);

        // Clear lands in the same cycle as B's edge on ch1: edge is lost.
        trg[1] = ~trg[1];
        for (int k = 1; k <= 12; k++) begin
            clr[1] = (k == 7);
            tick();
        end
        check_val("clr_cnt_b", bus_b.CNT_OUT[1*8 +: 8], 8'd0);
        check_val("clr_flg_b", bus_b.SAT_FLAG[1], 1'b0);
        check_val("clr_cnt_a", bus_a.CNT_OUT[1*32 +: 32], 32'd0);
        trg[1] = ~trg[1];
        repeat (12) tick();
        check_val("clr_resume_b", bus_b.CNT_OUT[1*8 +: 8], 8'd1);

        // Disabled counting, then re-enable with input held high.
        mode = 2'b00;
        saved_a = m_cnt[0][3];
        saved_b = m_cnt[1][3];
        en = 1'b0;
        pulses(3, 3, 6, 6);
        trg[3] = 1'b1;
        repeat (12) tick();
        en = 1'b1;
        repeat (10) tick();
        check_val("en_hold_a", bus_a.CNT_OUT[3*32 +: 32], saved_a);
        check_val("en_hold_b", bus_b.CNT_OUT[3*8 +: 8], saved_b[7:0]);

        // Out-of-range select taps channel 0.
        sel = 4'hF;
        repeat (3) tick();
        check_val("sel_oor_a", bus_a.PADDR_CNT, m_cnt[0][0][7:0]);

        // Asynchronous reset in the middle of a pulse.
        trg = ~trg;
        repeat (3) tick();
        #2 RESET_N = 1'b0;
        #1;
        check_val("arst_cnt_a", bus_a.CNT_OUT,  '0);
        check_val("arst_sat_a", bus_a.SAT_FLAG, '0);
        check_val("arst_tap_a", {bus_a.PADDR_CNT, bus_a.PLS_EDGE}, '0);
        check_val("arst_cnt_b", bus_b.CNT_OUT,  '0);
        check_val("arst_sat_b", bus_b.SAT_FLAG, '0);
        @(negedge CLK100M);
        RESET_N = 1'b1;
        reset_model();
        mode = 2'b10;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) trg = NCH'($urandom);
            sel = 4'($urandom_range(0, 15));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
